button_monitor_n_bit: RTL and testbench

Per-bit rising-edge detector for WIDTH asynchronous, active-high push-button inputs. Each bit is synchronised to the system clock and produces exactly one single-cycle `buttonEdge` pulse per press, however long the button is held. The block sits between the raw board buttons and the lock-control logic, which consumes single-cycle press events.

---
 rtl/button_monitor_n_bit.sv | 63 ++++++
 tb/tb_button_monitor_n_bit.sv | 112 +++++++++++
 2 files changed

// File: rtl/button_monitor_n_bit.sv
// Per-bit rising-edge detector for asynchronous push buttons.
// Each channel: two-flop synchroniser feeding an IDLE/EDGE/HELD FSM.
module button_monitor_n_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttonPress,
    output logic [WIDTH-1:0] buttonEdge
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDGE = 2'd1,
        HELD = 2'd2
    } state_t;

    logic [WIDTH-1:0] w_edge;

    for (genvar n = 0; n < WIDTH; n++) begin : g_chan
        logic   r_s1;
        logic   r_s2;
        state_t r_state;
        state_t w_next;

        // Bring the raw button level into the clock domain
        always_ff @(posedge clock) begin
            if (reset) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= buttonPress[n];
                r_s2 <= r_s1;
            end
        end

        // State register
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        // Next-state logic: one EDGE visit per press
        always_comb begin
            w_next = r_state;
            case (r_state)
                IDLE:    w_next = r_s2 ? EDGE : IDLE;
                EDGE:    w_next = r_s2 ? HELD : IDLE;
                HELD:    w_next = r_s2 ? HELD : IDLE;
                default: w_next = IDLE;
            endcase
        end

        // Pulse decoded straight from the state register
        assign w_edge[n] = (r_state == EDGE);
    end

    assign buttonEdge = w_edge;

endmodule

// File: tb/tb_button_monitor_n_bit.sv
// Directed bench for button_monitor_n_bit.
// Each step drives inputs, clocks once, then checks buttonEdge.
module tb_button_monitor_n_bit;

    logic       clock;
    logic       reset;
    logic [3:0] buttonPress;
    logic [3:0] buttonEdge;

    int n_chk = 0;
    int n_err = 0;

    button_monitor_n_bit #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .buttonPress (buttonPress),
        .buttonEdge  (buttonEdge)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] p,
                        input logic [3:0] e, input string tag);
        reset       = r;
        buttonPress = p;
        @(posedge clock);
        #1;
        chk(tag, buttonEdge, e);
    endtask

    initial begin
        reset       = 1'b1;
        buttonPress = 4'b0000;

        // reset
        step(1, 4'b0000, 4'b0000, "rst0");
        step(1, 4'b0000, 4'b0000, "rst1");

        // walking press, 2 cycles each
        step(0, 4'b0001, 4'b0000, "walk0");
        step(0, 4'b0001, 4'b0000, "walk1");
        step(0, 4'b0010, 4'b0001, "walk2");
        step(0, 4'b0010, 4'b0000, "walk3");
        step(0, 4'b0100, 4'b0010, "walk4");
        step(0, 4'b0100, 4'b0000, "walk5");
        step(0, 4'b1000, 4'b0100, "walk6");
        step(0, 4'b1000, 4'b0000, "walk7");
        step(0, 4'b0000, 4'b1000, "walk8");
        step(0, 4'b0000, 4'b0000, "walk9");
        step(0, 4'b0000, 4'b0000, "walk10");
        step(0, 4'b0000, 4'b0000, "walk11");

        // long hold of bit 0
        step(0, 4'b0001, 4'b0000, "hold0");
        step(0, 4'b0001, 4'b0000, "hold1");
        step(0, 4'b0001, 4'b0001, "hold2");
        for (int i = 3; i < 10; i++)
            step(0, 4'b0001, 4'b0000, $sformatf("hold%0d", i));
        step(0, 4'b0000, 4'b0000, "hold10");
        step(0, 4'b0000, 4'b0000, "hold11");
        step(0, 4'b0000, 4'b0000, "hold12");

        // release and re-press bit 2
        step(0, 4'b0100, 4'b0000, "rep0");
        step(0, 4'b0100, 4'b0000, "rep1");
        step(0, 4'b0100, 4'b0100, "rep2");
        step(0, 4'b0000, 4'b0000, "rep3");
        step(0, 4'b0000, 4'b0000, "rep4");
        step(0, 4'b0000, 4'b0000, "rep5");
        step(0, 4'b0100, 4'b0000, "rep6");
        step(0, 4'b0100, 4'b0000, "rep7");
        step(0, 4'b0100, 4'b0100, "rep8");
        step(0, 4'b0000, 4'b0000, "rep9");
        step(0, 4'b0000, 4'b0000, "rep10");
        step(0, 4'b0000, 4'b0000, "rep11");

        // simultaneous single-cycle press
        step(0, 4'b1111, 4'b0000, "sim0");
        step(0, 4'b0000, 4'b0000, "sim1");
        step(0, 4'b0000, 4'b1111, "sim2");
        step(0, 4'b0000, 4'b0000, "sim3");
        step(0, 4'b0000, 4'b0000, "sim4");

        // reset during hold of bit 3
        step(0, 4'b1000, 4'b0000, "rh0");
        step(0, 4'b1000, 4'b0000, "rh1");
        step(1, 4'b1000, 4'b0000, "rh2");
        step(1, 4'b1000, 4'b0000, "rh3");
        step(0, 4'b1000, 4'b0000, "rh4");
        step(0, 4'b1000, 4'b0000, "rh5");
        step(0, 4'b1000, 4'b1000, "rh6");
        step(0, 4'b1000, 4'b0000, "rh7");
        step(0, 4'b1000, 4'b0000, "rh8");
        step(0, 4'b0000, 4'b0000, "rh9");
        step(0, 4'b0000, 4'b0000, "rh10");
        step(0, 4'b0000, 4'b0000, "rh11");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
